// File: rtl/frame_commit_fifo_if.sv
// Handshake/status bundle between the demapper-side writer, the CRC verdict
// source and the UART-side reader of the frame commit FIFO.
interface frame_commit_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic              i_commit;
    logic              i_discard;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic              i_rd_en;
    logic [AW:0]       o_committed_cnt;
    logic [AW:0]       o_pending_cnt;
    logic              o_stall_err;

    modport slave (
        input  i_wr_data, i_wr_valid, i_commit, i_discard, i_rd_ready, i_rd_en,
        output o_wr_ready, o_rd_data, o_rd_valid, o_committed_cnt, o_pending_cnt,
               o_stall_err
    );

    modport master (
        output i_wr_data, i_wr_valid, i_commit, i_discard, i_rd_ready, i_rd_en,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_committed_cnt, o_pending_cnt,
               o_stall_err
    );
endinterface

// File: rtl/frame_commit_fifo.sv
// Payload FIFO holding each frame as pending until its CRC verdict; a good CRC
// makes the frame readable, a bad CRC rolls back only the pending words.
module frame_commit_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    frame_commit_fifo_if.slave   bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    // Extra MSB on each pointer distinguishes full from empty after wrap.
    logic [AW:0] rd_ptr, cm_ptr, wr_ptr;
    logic [AW:0] wr_nxt, used, committed;
    logic        wr_ready, rd_valid, wr_acc, pop, stall_err;

    always_comb begin
        used      = wr_ptr - rd_ptr;
        committed = cm_ptr - rd_ptr;
        wr_ready  = (used != FULL);
        rd_valid  = bus.i_rd_en && (committed != '0);
        wr_acc    = bus.i_wr_valid && wr_ready;
        pop       = rd_valid && bus.i_rd_ready;
        wr_nxt    = wr_acc ? (wr_ptr + ONE) : wr_ptr;
    end

    assign bus.o_wr_ready      = wr_ready;
    assign bus.o_rd_valid      = rd_valid;
    assign bus.o_rd_data       = mem[rd_ptr[AW-1:0]];
    assign bus.o_committed_cnt = committed;
    assign bus.o_pending_cnt   = wr_ptr - cm_ptr;
    assign bus.o_stall_err     = stall_err;

    // A write landing in the same cycle as a discard still hits the array,
    // but at a slot beyond cm_ptr, so it is never readable.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr    <= '0;
            cm_ptr    <= '0;
            wr_ptr    <= '0;
            stall_err <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + ONE;

            // Discard has priority over commit and drops a same-cycle write.
            if (bus.i_discard) begin
                wr_ptr <= cm_ptr;
            end else begin
                wr_ptr <= wr_nxt;
                if (bus.i_commit) cm_ptr <= wr_nxt;
            end

            if (bus.i_discard)
                stall_err <= 1'b0;
            else if (bus.i_wr_valid && !wr_ready && committed == '0)
                stall_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_commit_fifo.sv
// Drives a DEPTH=8 and a DEPTH=4 instance with identical stimulus and checks
// both against a queue-based model of committed/pending payload.
module tb_frame_commit_fifo;
    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       rst, wv, cm, ds, re, rr;
    logic [7:0] wd;

    frame_commit_fifo_if #(.DATA_W(8), .DEPTH(8)) f8 ();
    frame_commit_fifo_if #(.DATA_W(8), .DEPTH(4)) f4 ();

    frame_commit_fifo #(.DATA_W(8), .DEPTH(8)) dut8 (.i_clk(i_clk), .i_rst(rst), .bus(f8));
    frame_commit_fifo #(.DATA_W(8), .DEPTH(4)) dut4 (.i_clk(i_clk), .i_rst(rst), .bus(f4));

    assign f8.i_wr_data = wd;  assign f4.i_wr_data = wd;
    assign f8.i_wr_valid = wv; assign f4.i_wr_valid = wv;
    assign f8.i_commit = cm;   assign f4.i_commit = cm;
    assign f8.i_discard = ds;  assign f4.i_discard = ds;
    assign f8.i_rd_en = re;    assign f4.i_rd_en = re;
    assign f8.i_rd_ready = rr; assign f4.i_rd_ready = rr;

    logic       ob_rdy [2], ob_vld [2], ob_stall [2];
    logic [7:0] ob_data [2], ob_ccnt [2], ob_pcnt [2];
    assign ob_rdy[0]   = f8.o_wr_ready;  assign ob_rdy[1]   = f4.o_wr_ready;
    assign ob_vld[0]   = f8.o_rd_valid;  assign ob_vld[1]   = f4.o_rd_valid;
    assign ob_stall[0] = f8.o_stall_err; assign ob_stall[1] = f4.o_stall_err;
    assign ob_data[0]  = f8.o_rd_data;   assign ob_data[1]  = f4.o_rd_data;
    assign ob_ccnt[0]  = 8'(f8.o_committed_cnt); assign ob_ccnt[1] = 8'(f4.o_committed_cnt);
    assign ob_pcnt[0]  = 8'(f8.o_pending_cnt);   assign ob_pcnt[1] = 8'(f4.o_pending_cnt);

    // Model: readable words, words awaiting a verdict, sticky stall flag.
    logic [7:0] cq [2][$];
    logic [7:0] pq [2][$];
    logic       st [2];
    logic [7:0] popped8 [$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    // One clock cycle: apply inputs, compare pre-edge outputs, advance model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c,
                       input logic x, input logic e, input logic r);
        logic er, ev, acc, pp;
        wv = v; wd = d; cm = c; ds = x; re = e; rr = r;
        #3;
        for (int k = 0; k < 2; k++) begin
            er = ((cq[k].size() + pq[k].size()) != dep(k));
            ev = e && (cq[k].size() != 0);
            n_chk++;
            if (ob_rdy[k] !== er) begin
                n_fail++; $display("FAIL wr_ready d%0d t=%0t got %b exp %b", dep(k), $time, ob_rdy[k], er);
            end
            n_chk++;
            if (ob_vld[k] !== ev) begin
                n_fail++; $display("FAIL rd_valid d%0d t=%0t got %b exp %b", dep(k), $time, ob_vld[k], ev);
            end
            if (ev) begin
                n_chk++;
                if (ob_data[k] !== cq[k][0]) begin
                    n_fail++; $display("FAIL rd_data d%0d t=%0t got %h exp %h", dep(k), $time, ob_data[k], cq[k][0]);
                end
            end
            n_chk++;
            if (ob_ccnt[k] !== 8'(cq[k].size())) begin
                n_fail++; $display("FAIL committed_cnt d%0d t=%0t got %0d exp %0d", dep(k), $time, ob_ccnt[k], cq[k].size());
            end
            n_chk++;
            if (ob_pcnt[k] !== 8'(pq[k].size())) begin
                n_fail++; $display("FAIL pending_cnt d%0d t=%0t got %0d exp %0d", dep(k), $time, ob_pcnt[k], pq[k].size());
            end
            n_chk++;
            if (ob_stall[k] !== st[k]) begin
                n_fail++; $display("FAIL stall_err d%0d t=%0t got %b exp %b", dep(k), $time, ob_stall[k], st[k]);
            end
            acc = v && er;
            pp  = ev && r;
            if (x) st[k] = 1'b0;
            else if (v && !er && cq[k].size() == 0) st[k] = 1'b1;
            if (k == 0 && pp) popped8.push_back(ob_data[0]);
            if (pp) void'(cq[k].pop_front());
            if (acc) pq[k].push_back(d);
            if (x) pq[k].delete();
            else if (c) begin
                for (int i = 0; i < pq[k].size(); i++) cq[k].push_back(pq[k][i]);
                pq[k].delete();
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; wv = 0; wd = '0; cm = 0; ds = 0; re = 1; rr = 0;
        @(posedge i_clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cq[k].delete(); pq[k].delete(); st[k] = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cq[0].size() != 0 || cq[1].size() != 0) && n < 40) begin
            cyc(0, 8'h00, 0, 0, 1, 1);
            n++;
        end
        n_chk++;
        if (cq[0].size() != 0 || cq[1].size() != 0) begin
            n_fail++; $display("FAIL drain_timeout got %0d/%0d left exp 0", cq[0].size(), cq[1].size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({ob_rdy[k], ob_vld[k], ob_stall[k], ob_ccnt[k], ob_pcnt[k]} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
                n_fail++; $display("FAIL reset_state d%0d got rdy=%b vld=%b st=%b c=%0d p=%0d exp 1 0 0 0 0",
                                   dep(k), ob_rdy[k], ob_vld[k], ob_stall[k], ob_ccnt[k], ob_pcnt[k]);
            end
        end
    endtask

    task automatic test_basic_frame();
        popped8.delete();
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0, 1, 1);
        cyc(0, 8'h00, 1, 0, 1, 1);
        n_chk++;
        if (ob_vld[0] !== 1'b1 || ob_ccnt[0] !== 8'd5) begin
            n_fail++; $display("FAIL basic_after_commit got vld=%b cnt=%0d exp 1 5", ob_vld[0], ob_ccnt[0]);
        end
        drain();
        n_chk++;
        if (popped8.size() != 5) begin
            n_fail++; $display("FAIL basic_count got %0d exp 5", popped8.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (popped8[i] !== 8'(i + 1)) begin
                    n_fail++; $display("FAIL basic_order[%0d] got %h exp %h", i, popped8[i], 8'(i + 1));
                end
            end
        end
        cyc(0, 8'h00, 0, 1, 1, 1);  // clears the stall the 4-deep copy hit
    endtask

    task automatic test_rollback();
        logic [7:0] exp_q [$];
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
        popped8.delete();
        cyc(1, 8'hA0, 0, 0, 1, 1);
        cyc(1, 8'hA1, 0, 0, 1, 1);
        cyc(1, 8'hA2, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'hB0 + 8'(i), 0, 0, 1, 1);
        cyc(0, 8'h00, 0, 1, 1, 1);
        n_chk++;
        if (ob_pcnt[0] !== 8'd0) begin
            n_fail++; $display("FAIL rollback_pending got %0d exp 0", ob_pcnt[0]);
        end
        for (int i = 0; i < 3; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 1, 1);
        cyc(0, 8'h00, 1, 0, 1, 1);
        drain();
        n_chk++;
        if (popped8 != exp_q) begin
            n_fail++; $display("FAIL rollback_order got %p exp %p", popped8, exp_q);
        end
    endtask

    task automatic test_simultaneous();
        popped8.delete();
        cyc(1, 8'h11, 0, 0, 0, 0);
        cyc(1, 8'h12, 1, 0, 0, 0);
        n_chk++;
        if (ob_ccnt[0] !== 8'd2 || ob_pcnt[0] !== 8'd0) begin
            n_fail++; $display("FAIL commit_with_write got c=%0d p=%0d exp 2 0", ob_ccnt[0], ob_pcnt[0]);
        end
        cyc(1, 8'h13, 0, 0, 0, 0);
        cyc(1, 8'h14, 0, 1, 0, 0);
        n_chk++;
        if (ob_ccnt[0] !== 8'd2 || ob_pcnt[0] !== 8'd0) begin
            n_fail++; $display("FAIL discard_with_write got c=%0d p=%0d exp 2 0", ob_ccnt[0], ob_pcnt[0]);
        end
        cyc(1, 8'h15, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 1, 0, 0);
        n_chk++;
        if (ob_ccnt[0] !== 8'd2 || ob_pcnt[0] !== 8'd0) begin
            n_fail++; $display("FAIL commit_and_discard got c=%0d p=%0d exp 2 0", ob_ccnt[0], ob_pcnt[0]);
        end
        drain();
        n_chk++;
        if (popped8.size() != 2 || popped8[0] !== 8'h11 || popped8[1] !== 8'h12) begin
            n_fail++; $display("FAIL simultaneous_data got %p exp 11 12", popped8);
        end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 0, 1, 1);
        cyc(1, 8'($urandom), 0, 0, 1, 1);
        n_chk++;
        if (ob_rdy[0] !== 1'b0 || ob_stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL full_stall got rdy=%b st=%b exp 0 1", ob_rdy[0], ob_stall[0]);
        end
        cyc(0, 8'h00, 1, 0, 0, 0);  // commit must leave the stall flag set
        n_chk++;
        if (ob_stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL stall_after_commit got %b exp 1", ob_stall[0]);
        end
        drain();
        for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 0, 1, 1);
        cyc(0, 8'h00, 0, 1, 1, 1);
        n_chk++;
        if (ob_rdy[0] !== 1'b1 || ob_stall[0] !== 1'b0 || ob_pcnt[0] !== 8'd0) begin
            n_fail++; $display("FAIL stall_cleared got rdy=%b st=%b p=%0d exp 1 0 0", ob_rdy[0], ob_stall[0], ob_pcnt[0]);
        end
    endtask

    task automatic test_wrap();
        int fin;
        for (int f = 0; f < 20; f++) begin
            fin = int'($urandom_range(0, 2));
            cyc(1, 8'($urandom), 0, 0, 1, 1'($urandom_range(0, 1)));
            cyc(1, 8'($urandom), 0, 0, 1, 1'($urandom_range(0, 1)));
            cyc(1, 8'($urandom), fin == 2, 0, 1, 1'($urandom_range(0, 1)));
            if (fin != 2) cyc(0, 8'h00, fin == 1, fin == 0, 1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) cyc(0, 8'h00, 0, 0, 1, 1'($urandom_range(0, 1)));
        end
        drain();
        cyc(0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), i == 2, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, 0, 0, 0, 1);
        n_chk++;
        if (ob_ccnt[1] !== 8'd3 || ob_vld[1] !== 1'b0) begin
            n_fail++; $display("FAIL rd_en_gate got c=%0d vld=%b exp 3 0", ob_ccnt[1], ob_vld[1]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), i == 2, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 8'($urandom), 0, 0, 0, 0);
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({ob_rdy[k], ob_vld[k], ob_ccnt[k], ob_pcnt[k]} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
                n_fail++; $display("FAIL reset_mid d%0d got rdy=%b vld=%b c=%0d p=%0d exp 1 0 0 0",
                                   dep(k), ob_rdy[k], ob_vld[k], ob_ccnt[k], ob_pcnt[k]);
            end
        end
        cyc(0, 8'h00, 0, 0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_rollback();
        test_simultaneous();
        test_full_stall();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
